// File: rtl/itransform_pipe.sv
// VP8/WebP 4x4 inverse transform with prediction add and clip, two-stage valid/ready pipeline.
// Build option: define ITRANSFORM_DC_ONLY_EN to honour per-beat in_dc_only (DC-only reconstruction).
module itransform_pipe #(
  parameter int SRC_WIDTH = 16,
  parameter int REF_WIDTH = 8,
  parameter int OUT_WIDTH = 8,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*SRC_WIDTH-1:0] in_src,
  input  logic [16*REF_WIDTH-1:0] in_ref,
  input  logic                    in_dc_only,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*OUT_WIDTH-1:0] out_pix,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [CNT_WIDTH-1:0]    blk_cnt
);
  localparam int TW  = SRC_WIDTH + 3;
  localparam int SW  = TW + 3;
  localparam int PW  = SW + 18;
  localparam int PXW = ((SW > REF_WIDTH) ? SW : REF_WIDTH) + 2;

  localparam logic signed [PW-1:0]  K_MUL1  = PW'(85627);
  localparam logic signed [PW-1:0]  K_MUL2  = PW'(35468);
  localparam logic signed [PXW-1:0] PIX_MAX = PXW'((1 << OUT_WIDTH) - 1);

  // Q16 constant multiply; the product is wide enough that nothing is lost before the shift.
  function automatic logic signed [SW-1:0] mul_q16(input logic signed [SW-1:0] x,
                                                   input logic signed [PW-1:0] k);
    logic signed [PW-1:0] p;
    p = PW'(x) * k;
    return SW'(p >>> 16);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] clip_pix(input logic signed [PXW-1:0] v);
    if (v[PXW-1])         return '0;
    else if (v > PIX_MAX) return '1;
    else                  return v[OUT_WIDTH-1:0];
  endfunction

  logic                    adv;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [TW-1:0]    t_p1_q [16];
  logic signed [TW-1:0]    t_p1_d [16];
  logic [16*REF_WIDTH-1:0] ref_p1_q, ref_p1_d;
  logic [TAG_WIDTH-1:0]    tag_p1_q, tag_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic [16*OUT_WIDTH-1:0] pix_p2_q, pix_p2_d;
  logic [TAG_WIDTH-1:0]    tag_p2_q, tag_p2_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic signed [SW-1:0]    c_in   [16];
  logic signed [SW-1:0]    sum_p2 [16];
  logic                    dc_sel_p2;

`ifdef ITRANSFORM_DC_ONLY_EN
  logic dc_p1_q, dc_p1_d;
  assign dc_sel_p2 = dc_p1_q;
`else
  logic dc_unused;
  assign dc_unused = in_dc_only;
  assign dc_sel_p2 = 1'b0;
`endif

  assign adv       = !vld_p2_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign out_pix   = pix_p2_q;
  assign out_tag   = tag_p2_q;
  assign blk_cnt   = cnt_q;

  always_comb begin
    for (int k = 0; k < 16; k++)
      c_in[k] = SW'($signed(in_src[SRC_WIDTH*k +: SRC_WIDTH]));
  end

  // S1: vertical pass on the incoming block
  always_comb begin
    logic signed [SW-1:0] a0, a1, a2, a3;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    vld_p1_d = vld_p1_q;
    t_p1_d   = t_p1_q;
    ref_p1_d = ref_p1_q;
    tag_p1_d = tag_p1_q;
`ifdef ITRANSFORM_DC_ONLY_EN
    dc_p1_d  = dc_p1_q;
`endif
    if (adv) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          a0 = c_in[i] + c_in[i+8];
          a1 = c_in[i] - c_in[i+8];
          a2 = mul_q16(c_in[i+4], K_MUL2) - mul_q16(c_in[i+12], K_MUL1);
          a3 = mul_q16(c_in[i+4], K_MUL1) + mul_q16(c_in[i+12], K_MUL2);
          t_p1_d[4*i+0] = TW'(a0 + a3);
          t_p1_d[4*i+1] = TW'(a1 + a2);
          t_p1_d[4*i+2] = TW'(a1 - a2);
          t_p1_d[4*i+3] = TW'(a0 - a3);
        end
        ref_p1_d = in_ref;
        tag_p1_d = in_tag;
`ifdef ITRANSFORM_DC_ONLY_EN
        // A DC-only beat parks the raw DC term in slot 0; S2 broadcasts it.
        dc_p1_d = in_dc_only;
        if (in_dc_only) t_p1_d[0] = TW'(c_in[0]);
`endif
      end
    end
  end

  // S2: horizontal pass, rounding, prediction add and clip
  always_comb begin
    logic signed [SW-1:0] b0, b1, b2, b3, t0, t4, t8, t12;
    for (int i = 0; i < 4; i++) begin
      t0  = SW'(t_p1_q[i]);
      t4  = SW'(t_p1_q[i+4]);
      t8  = SW'(t_p1_q[i+8]);
      t12 = SW'(t_p1_q[i+12]);
      b0 = t0 + t8 + SW'(4);
      b1 = t0 - t8 + SW'(4);
      b2 = mul_q16(t4, K_MUL2) - mul_q16(t12, K_MUL1);
      b3 = mul_q16(t4, K_MUL1) + mul_q16(t12, K_MUL2);
      sum_p2[4*i+0] = b0 + b3;
      sum_p2[4*i+1] = b1 + b2;
      sum_p2[4*i+2] = b1 - b2;
      sum_p2[4*i+3] = b0 - b3;
    end
    if (dc_sel_p2) begin
      for (int k = 0; k < 16; k++) sum_p2[k] = SW'(t_p1_q[0]) + SW'(4);
    end
  end

  always_comb begin
    vld_p2_d = vld_p2_q;
    pix_p2_d = pix_p2_q;
    tag_p2_d = tag_p2_q;
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        for (int k = 0; k < 16; k++)
          pix_p2_d[OUT_WIDTH*k +: OUT_WIDTH] =
            clip_pix(PXW'($signed({1'b0, ref_p1_q[REF_WIDTH*k +: REF_WIDTH]})) +
                     PXW'(sum_p2[k] >>> 3));
        tag_p2_d = tag_p1_q;
      end
    end
    cnt_d = cnt_q;
    if (vld_p2_q && out_ready) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      for (int k = 0; k < 16; k++) t_p1_q[k] <= '0;
      ref_p1_q <= '0;
      tag_p1_q <= '0;
`ifdef ITRANSFORM_DC_ONLY_EN
      dc_p1_q  <= 1'b0;
`endif
      vld_p2_q <= 1'b0;
      pix_p2_q <= '0;
      tag_p2_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      t_p1_q   <= t_p1_d;
      ref_p1_q <= ref_p1_d;
      tag_p1_q <= tag_p1_d;
`ifdef ITRANSFORM_DC_ONLY_EN
      dc_p1_q  <= dc_p1_d;
`endif
      vld_p2_q <= vld_p2_d;
      pix_p2_q <= pix_p2_d;
      tag_p2_q <= tag_p2_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_itransform_pipe.sv
// Self-checking bench for itransform_pipe: directed and randomised blocks scored against
// a libwebp-style TransformOne + clip reference model.
`timescale 1ns/1ps
module tb_itransform_pipe;
`ifdef ITRANSFORM_DC_ONLY_EN
  localparam bit USE_DC = 1'b1;
`else
  localparam bit USE_DC = 1'b0;
`endif

  typedef struct {
    logic [255:0] src;
    logic [127:0] rf;
    bit           dc;
    logic [7:0]   tag;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_dc_only = 1'b0;
  logic         out_ready = 1'b1;
  logic [255:0] in_src = '0;
  logic [127:0] in_ref = '0;
  logic [7:0]   in_tag = '0;
  logic         in_ready, out_valid, w_in_ready, w_out_valid;
  logic [127:0] out_pix, w_pix;
  logic [7:0]   out_tag, w_tag;
  logic [15:0]  blk_cnt;
  logic [3:0]   w_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  beat_t        stim[$];
  logic [127:0] obs_pix[$];
  logic [7:0]   obs_tag[$];
  int           acc_cyc[$];
  int           xfer_cyc[$];
  int           stall_err, rdy_err, twin_err;
  bit           timed_out;

  always #5 clk = ~clk;

  itransform_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_ref(in_ref), .in_dc_only(in_dc_only), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_tag(out_tag), .blk_cnt(blk_cnt));

  itransform_pipe #(.CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_src(in_src), .in_ref(in_ref), .in_dc_only(in_dc_only), .in_tag(in_tag),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pix(w_pix),
    .out_tag(w_tag), .blk_cnt(w_cnt));

  function automatic longint mul1(input longint x);
    return ((x * 20091) >>> 16) + x;
  endfunction

  function automatic longint mul2(input longint x);
    return (x * 35468) >>> 16;
  endfunction

  function automatic logic [7:0] clip8(input longint v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [127:0] model(input beat_t b);
    longint c[16];
    longint t[16];
    longint a, bb, cc, d, rv;
    logic [127:0] px;
    px = '0;
    for (int k = 0; k < 16; k++) c[k] = $signed(b.src[16*k +: 16]);
    if (USE_DC && b.dc) begin
      for (int k = 0; k < 16; k++) begin
        rv = b.rf[8*k +: 8];
        px[8*k +: 8] = clip8(rv + ((c[0] + 4) >>> 3));
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        a  = c[i] + c[i+8];
        bb = c[i] - c[i+8];
        cc = mul2(c[i+4]) - mul1(c[i+12]);
        d  = mul1(c[i+4]) + mul2(c[i+12]);
        t[4*i+0] = a + d;  t[4*i+1] = bb + cc;
        t[4*i+2] = bb - cc; t[4*i+3] = a - d;
      end
      for (int i = 0; i < 4; i++) begin
        a  = t[i] + 4 + t[i+8];
        bb = t[i] + 4 - t[i+8];
        cc = mul2(t[i+4]) - mul1(t[i+12]);
        d  = mul1(t[i+4]) + mul2(t[i+12]);
        rv = b.rf[8*(4*i+0) +: 8]; px[8*(4*i+0) +: 8] = clip8(rv + ((a + d) >>> 3));
        rv = b.rf[8*(4*i+1) +: 8]; px[8*(4*i+1) +: 8] = clip8(rv + ((bb + cc) >>> 3));
        rv = b.rf[8*(4*i+2) +: 8]; px[8*(4*i+2) +: 8] = clip8(rv + ((bb - cc) >>> 3));
        rv = b.rf[8*(4*i+3) +: 8]; px[8*(4*i+3) +: 8] = clip8(rv + ((a - d) >>> 3));
      end
    end
    return px;
  endfunction

  function automatic beat_t rand_beat(input bit dc);
    beat_t b;
    int v;
    for (int k = 0; k < 16; k++) begin
      v = $urandom_range(0, 1023) - 512;
      if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 65535) - 32768;
      b.src[16*k +: 16] = 16'(v);
      b.rf[8*k +: 8] = 8'($urandom);
    end
    b.dc = dc;
    b.tag = 8'($urandom);
    return b;
  endfunction

  function automatic beat_t const_beat(input int c0, input int c5, input logic [7:0] rv,
                                       input logic [7:0] tag, input bit dc);
    beat_t b;
    b.src = '0;
    b.src[15:0] = 16'(c0);
    b.src[16*5 +: 16] = 16'(c5);
    b.rf = {16{rv}};
    b.dc = dc;
    b.tag = tag;
    return b;
  endfunction

  // Plays stim through the handshake (entered and left on a falling edge), recording outputs.
  task automatic drive_blocks(input bit rand_ready);
    int idx;
    int cyc;
    bit held;
    logic [127:0] hp;
    logic [7:0] ht;
    idx = 0; cyc = 0; held = 0; hp = '0; ht = '0;
    obs_pix.delete(); obs_tag.delete(); acc_cyc.delete(); xfer_cyc.delete();
    stall_err = 0; rdy_err = 0; twin_err = 0; timed_out = 0;
    while (obs_pix.size() < stim.size()) begin
      if (cyc > 2000) begin
        timed_out = 1;
        break;
      end
      in_valid = (idx < stim.size());
      if (idx < stim.size()) begin
        in_src = stim[idx].src; in_ref = stim[idx].rf;
        in_tag = stim[idx].tag; in_dc_only = stim[idx].dc;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_ready !== (!out_valid || out_ready)) rdy_err++;
      if (held && (out_valid !== 1'b1 || out_pix !== hp || out_tag !== ht)) stall_err++;
      if (w_out_valid !== out_valid || w_in_ready !== in_ready ||
          (out_valid && (w_pix !== out_pix || w_tag !== out_tag))) twin_err++;
      held = out_valid && !out_ready;
      hp = out_pix; ht = out_tag;
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (out_valid && out_ready) begin
        obs_pix.push_back(out_pix);
        obs_tag.push_back(out_tag);
        xfer_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (timed_out) $display("FAIL drive_timeout got=%0d outputs exp=%0d", obs_pix.size(), stim.size());
    while (obs_pix.size() < stim.size()) begin
      obs_pix.push_back('x); obs_tag.push_back('x); xfer_cyc.push_back(-1000);
    end
    while (acc_cyc.size() < stim.size()) acc_cyc.push_back(-1000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_pix !== '0) begin bad++; $display("FAIL rst_out_pix got=%h exp=0", out_pix); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
    total++; if (blk_cnt !== '0) begin bad++; $display("FAIL rst_blk_cnt got=%0d exp=0", blk_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_zero;
    stim.delete();
    stim.push_back(const_beat(0, 0, 8'h80, 8'h5A, 1'b0));
    drive_blocks(1'b0);
    exp_cnt += 1;
    total++; if (obs_pix[0] !== {16{8'h80}}) begin bad++; $display("FAIL zero_pix got=%h exp=%h", obs_pix[0], {16{8'h80}}); end
    total++; if (obs_tag[0] !== 8'h5A) begin bad++; $display("FAIL zero_tag got=%h exp=5a", obs_tag[0]); end
    total++; if (xfer_cyc[0] - acc_cyc[0] !== 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", xfer_cyc[0] - acc_cyc[0]); end
    total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL zero_blk_cnt got=%0d exp=%0d", blk_cnt, exp_cnt); end
  endtask

  task automatic test_dc80;
    stim.delete();
    stim.push_back(const_beat(80, 0, 8'd100, 8'hC3, 1'b0));
    drive_blocks(1'b0);
    exp_cnt += 1;
    total++; if (obs_pix[0] !== {16{8'd110}}) begin bad++; $display("FAIL dc80_pix got=%h exp=%h", obs_pix[0], {16{8'd110}}); end
    total++; if (obs_tag[0] !== 8'hC3) begin bad++; $display("FAIL dc80_tag got=%h exp=c3", obs_tag[0]); end
  endtask

  task automatic test_saturation;
    stim.delete();
    stim.push_back(const_beat(32767, 0, 8'd255, 8'h01, 1'b0));
    stim.push_back(const_beat(-32768, 0, 8'd0, 8'h02, 1'b0));
    drive_blocks(1'b0);
    exp_cnt += 2;
    total++; if (obs_pix[0] !== {16{8'hFF}}) begin bad++; $display("FAIL sat_high got=%h exp=%h", obs_pix[0], {16{8'hFF}}); end
    total++; if (obs_pix[1] !== '0) begin bad++; $display("FAIL sat_low got=%h exp=0", obs_pix[1]); end
    total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL sat_blk_cnt got=%0d exp=%0d", blk_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back;
    int c0;
    stim.delete();
    for (int n = 0; n < 10; n++) stim.push_back(rand_beat(1'($urandom_range(0, 1))));
    c0 = exp_cnt;
    drive_blocks(1'b1);
    exp_cnt += 10;
    for (int n = 0; n < 10; n++) begin
      total++; if (obs_pix[n] !== model(stim[n])) begin bad++; $display("FAIL b2b_pix[%0d] got=%h exp=%h", n, obs_pix[n], model(stim[n])); end
      total++; if (obs_tag[n] !== stim[n].tag) begin bad++; $display("FAIL b2b_tag[%0d] got=%h exp=%h", n, obs_tag[n], stim[n].tag); end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL b2b_stall_stable got=%0d exp=0", stall_err); end
    total++; if (rdy_err !== 0) begin bad++; $display("FAIL b2b_in_ready got=%0d exp=0", rdy_err); end
    total++; if (blk_cnt - 16'(c0) !== 16'd10) begin bad++; $display("FAIL b2b_blk_cnt got=%0d exp=10", blk_cnt - 16'(c0)); end
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_extra got=%b exp=0", out_valid); end
  endtask

  task automatic test_throughput;
    stim.delete();
    for (int n = 0; n < 8; n++) stim.push_back(rand_beat(1'b0));
    drive_blocks(1'b0);
    exp_cnt += 8;
    total++; if (xfer_cyc[7] - xfer_cyc[0] !== 7) begin bad++; $display("FAIL tput_span got=%0d exp=7", xfer_cyc[7] - xfer_cyc[0]); end
    total++; if (acc_cyc[7] - acc_cyc[0] !== 7) begin bad++; $display("FAIL tput_accept got=%0d exp=7", acc_cyc[7] - acc_cyc[0]); end
    for (int n = 0; n < 8; n++) begin
      total++; if (obs_pix[n] !== model(stim[n])) begin bad++; $display("FAIL tput_pix[%0d] got=%h exp=%h", n, obs_pix[n], model(stim[n])); end
    end
  endtask

  task automatic test_dc_only;
    logic [127:0] e;
    stim.delete();
    stim.push_back(const_beat(-24, 1000, 8'd50, 8'h77, 1'b1));
    for (int n = 0; n < 8; n++) stim.push_back(rand_beat(n[0]));
    drive_blocks(1'b1);
    exp_cnt += 9;
    e = USE_DC ? {16{8'd47}} : model(stim[0]);
    total++; if (obs_pix[0] !== e) begin bad++; $display("FAIL dc_only_pix got=%h exp=%h", obs_pix[0], e); end
    for (int n = 1; n < 9; n++) begin
      total++; if (obs_pix[n] !== model(stim[n])) begin bad++; $display("FAIL dc_mix_pix[%0d] got=%h exp=%h", n, obs_pix[n], model(stim[n])); end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL dc_mix_stall_stable got=%0d exp=0", stall_err); end
  endtask

  task automatic test_reset_midstream;
    beat_t a, b;
    a = rand_beat(1'b0);
    b = rand_beat(1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_dc_only = 1'b0;
    in_src = a.src; in_ref = a.rf; in_tag = a.tag;
    @(negedge clk);
    in_src = b.src; in_ref = b.rf; in_tag = b.tag;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_prefill got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if (blk_cnt !== '0) begin bad++; $display("FAIL midrst_blk_cnt got=%0d exp=0", blk_cnt); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; exp_cnt = 0;
    stim.delete();
    stim.push_back(rand_beat(1'b0));
    drive_blocks(1'b0);
    exp_cnt = 1;
    total++; if (obs_pix[0] !== model(stim[0])) begin bad++; $display("FAIL midrst_next_pix got=%h exp=%h", obs_pix[0], model(stim[0])); end
    total++; if (xfer_cyc[0] - acc_cyc[0] !== 2) begin bad++; $display("FAIL midrst_latency got=%0d exp=2", xfer_cyc[0] - acc_cyc[0]); end
    total++; if (blk_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL midrst_cnt_after got=%0d exp=1", blk_cnt); end
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    stim.delete();
    for (int n = 0; n < 17; n++) stim.push_back(rand_beat(1'b0));
    drive_blocks(1'b0);
    exp_cnt = 17;
    total++; if (w_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt4 got=%0d exp=1", w_cnt); end
    total++; if (blk_cnt !== 16'd17) begin bad++; $display("FAIL wrap_cnt16 got=%0d exp=17", blk_cnt); end
    total++; if (twin_err !== 0) begin bad++; $display("FAIL wrap_twin_outputs got=%0d exp=0", twin_err); end
    total++; if (obs_pix[16] !== model(stim[16])) begin bad++; $display("FAIL wrap_last_pix got=%h exp=%h", obs_pix[16], model(stim[16])); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc80();
    test_saturation();
    test_back_to_back();
    test_throughput();
    test_dc_only();
    test_reset_midstream();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
